// File: rtl/nf_bypass_order_sched_pkg.sv
// Shared types for the NF/bypass steering and in-order merge scheduler.
package nf_sched_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT_NF = 2'd1, GRANT_BP = 2'd2} sched_state_t;
  localparam logic PATH_BP = 1'b0;
  localparam logic PATH_NF = 1'b1;
endpackage

// File: rtl/nf_bypass_order_sched_fifo.sv
// 1-bit order-tag FIFO: records which path each accepted packet took.
module order_tag_fifo #(
  parameter int DEPTH = 32
) (
  input  logic                       Clk,
  input  logic                       Rst,
  input  logic                       i_push,
  input  logic                       i_push_tag,
  input  logic                       i_pop,
  output logic                       o_head,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_full,
  output logic                       o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] r_mem;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  // full/empty come from the registered count, so a same-cycle pop never
  // frees room for a push and a same-cycle push never feeds a pop
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_mem    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_tag;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/nf_bypass_order_sched.sv
// Steers packets to NF or bypass and merges the two output streams back
// into arrival order; drives mux selects/readies only, carries no data.
module nf_bypass_order_sched
  import nf_sched_pkg::*;
#(
  parameter int ORDER_DEPTH    = 32,
  parameter int NF_FULL_THRESH = 480
) (
  input  logic                             Clk,
  input  logic                             Rst,
  input  logic                             in_meta_valid,
  input  logic                             in_meta_need_nf,
  output logic                             in_meta_ready,
  input  logic [31:0]                      nf_fill_level,
  output logic                             route_valid,
  output logic                             route_nf,
  input  logic                             route_ready,
  input  logic                             nf_pkt_valid,
  input  logic                             nf_pkt_eop,
  output logic                             nf_pkt_ready,
  input  logic                             bp_pkt_valid,
  input  logic                             bp_pkt_eop,
  output logic                             bp_pkt_ready,
  input  logic                             out_pkt_ready,
  output logic                             out_pkt_valid,
  output logic                             sel_nf,
  output logic [$clog2(ORDER_DEPTH+1)-1:0] order_fill,
  output logic [31:0]                      stats_route_nf,
  output logic [31:0]                      stats_route_bp
);
  logic         w_full, w_empty, w_head, w_pop, w_done;
  logic         w_nf_cong, w_accept;
  logic         r_route_valid, r_route_nf, r_sel_nf;
  logic [31:0]  r_stats_nf, r_stats_bp;
  sched_state_t r_state, w_state_nxt;

  // need-NF packets wait out congestion; they are never diverted to bypass
  assign w_nf_cong     = (nf_fill_level >= 32'(NF_FULL_THRESH));
  assign in_meta_ready = !Rst && (!r_route_valid || route_ready) && !w_full &&
                         !(in_meta_need_nf && w_nf_cong);
  assign w_accept      = in_meta_valid && in_meta_ready;

  assign route_valid    = r_route_valid;
  assign route_nf       = r_route_nf;
  assign stats_route_nf = r_stats_nf;
  assign stats_route_bp = r_stats_bp;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_route_valid <= 1'b0;
      r_route_nf    <= PATH_BP;
      r_stats_nf    <= '0;
      r_stats_bp    <= '0;
    end else begin
      if (w_accept) begin
        r_route_valid <= 1'b1;
        r_route_nf    <= in_meta_need_nf;
        if (in_meta_need_nf) r_stats_nf <= r_stats_nf + 32'd1;
        else                 r_stats_bp <= r_stats_bp + 32'd1;
      end else if (route_ready) begin
        r_route_valid <= 1'b0;
      end
    end
  end

  order_tag_fifo #(.DEPTH(ORDER_DEPTH)) u_tag_fifo (
    .Clk        (Clk),
    .Rst        (Rst),
    .i_push     (w_accept),
    .i_push_tag (in_meta_need_nf),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_count    (order_fill),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state  <= IDLE;
      r_sel_nf <= PATH_BP;
    end else begin
      r_state  <= w_state_nxt;
      r_sel_nf <= sel_nf;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pop         = 1'b0;
    w_done        = 1'b0;
    nf_pkt_ready  = 1'b0;
    bp_pkt_ready  = 1'b0;
    out_pkt_valid = 1'b0;
    sel_nf        = r_sel_nf;
    case (r_state)
      IDLE: ;
      GRANT_NF: begin
        sel_nf        = PATH_NF;
        nf_pkt_ready  = out_pkt_ready;
        out_pkt_valid = nf_pkt_valid;
        w_done        = nf_pkt_valid && out_pkt_ready && nf_pkt_eop;
      end
      GRANT_BP: begin
        sel_nf        = PATH_BP;
        bp_pkt_ready  = out_pkt_ready;
        out_pkt_valid = bp_pkt_valid;
        w_done        = bp_pkt_valid && out_pkt_ready && bp_pkt_eop;
      end
      default: w_state_nxt = IDLE;
    endcase
    // eop hands straight over to the next queued packet, no idle bubble
    if (r_state == IDLE || w_done) begin
      if (!w_empty) begin
        w_pop       = 1'b1;
        w_state_nxt = (w_head == PATH_NF) ? GRANT_NF : GRANT_BP;
      end else begin
        w_state_nxt = IDLE;
      end
    end
  end
endmodule

// File: tb/tb_nf_bypass_order_sched.sv
// Scoreboard bench: arrival-order tags queued at meta accept, checked at merge.
module tb_nf_bypass_order_sched;
  import nf_sched_pkg::*;
  localparam int DEPTH = 32;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          Clk = 1'b0, Rst = 1'b1;
  logic          in_meta_valid = 1'b0, in_meta_need_nf = 1'b0, in_meta_ready;
  logic [31:0]   nf_fill_level = 32'd0;
  logic          route_valid, route_nf, route_ready = 1'b1;
  logic          nf_pkt_valid = 1'b0, nf_pkt_eop = 1'b0, nf_pkt_ready;
  logic          bp_pkt_valid = 1'b0, bp_pkt_eop = 1'b0, bp_pkt_ready;
  logic          out_pkt_ready = 1'b1, out_pkt_valid, sel_nf;
  logic [CW-1:0] order_fill;
  logic [31:0]   stats_route_nf, stats_route_bp;

  always #5 Clk = ~Clk;

  nf_bypass_order_sched #(.ORDER_DEPTH(DEPTH), .NF_FULL_THRESH(480)) dut (
    .Clk(Clk), .Rst(Rst),
    .in_meta_valid(in_meta_valid), .in_meta_need_nf(in_meta_need_nf), .in_meta_ready(in_meta_ready),
    .nf_fill_level(nf_fill_level),
    .route_valid(route_valid), .route_nf(route_nf), .route_ready(route_ready),
    .nf_pkt_valid(nf_pkt_valid), .nf_pkt_eop(nf_pkt_eop), .nf_pkt_ready(nf_pkt_ready),
    .bp_pkt_valid(bp_pkt_valid), .bp_pkt_eop(bp_pkt_eop), .bp_pkt_ready(bp_pkt_ready),
    .out_pkt_ready(out_pkt_ready), .out_pkt_valid(out_pkt_valid), .sel_nf(sel_nf),
    .order_fill(order_fill), .stats_route_nf(stats_route_nf), .stats_route_bp(stats_route_bp)
  );

  int   n_cmp = 0, n_err = 0;
  logic exp_q[$];
  int   nf_q[$], bp_q[$];
  int   nf_beat = 0, bp_beat = 0;
  logic nf_en = 1'b1, bp_en = 1'b1;
  logic nf_fire = 1'b0, bp_fire = 1'b0;

  // Path sources and merge monitor: drive at negedge, sample at negedge+1.
  always @(negedge Clk) begin
    if (Rst) begin
      nf_q.delete(); bp_q.delete(); exp_q.delete();
      nf_beat = 0; bp_beat = 0; nf_fire = 1'b0; bp_fire = 1'b0;
    end else begin
      if (nf_fire) begin
        if (nf_pkt_eop) begin void'(nf_q.pop_front()); nf_beat = 0; end
        else nf_beat++;
      end
      if (bp_fire) begin
        if (bp_pkt_eop) begin void'(bp_q.pop_front()); bp_beat = 0; end
        else bp_beat++;
      end
    end
    nf_pkt_valid = nf_en && (nf_q.size() > 0);
    nf_pkt_eop   = 1'b0;
    if (nf_pkt_valid) nf_pkt_eop = (nf_beat == nf_q[0] - 1);
    bp_pkt_valid = bp_en && (bp_q.size() > 0);
    bp_pkt_eop   = 1'b0;
    if (bp_pkt_valid) bp_pkt_eop = (bp_beat == bp_q[0] - 1);
    #1;
    nf_fire = nf_pkt_valid && nf_pkt_ready;
    bp_fire = bp_pkt_valid && bp_pkt_ready;
    if (!Rst && out_pkt_valid && out_pkt_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL merge_unexpected: beat with sel_nf=%0b, expected no packet", sel_nf);
      end else begin
        if (sel_nf !== exp_q[0]) begin
          n_err++;
          $display("FAIL merge_order: sel_nf=%0b expected %0b", sel_nf, exp_q[0]);
        end
        if (sel_nf ? nf_pkt_eop : bp_pkt_eop) void'(exp_q.pop_front());
      end
    end
  end

  // Offer one meta beat; report acceptance and the route seen the cycle after.
  task automatic send_meta(input logic need, input int len, input int max_wait,
                           output logic ok, output logic rv, output logic rn);
    int w = 0;
    @(negedge Clk);
    in_meta_valid = 1'b1; in_meta_need_nf = need;
    #1;
    while (!in_meta_ready && w < max_wait) begin @(negedge Clk); #1; w++; end
    ok = in_meta_ready;
    if (ok) begin
      exp_q.push_back(need);
      if (need) nf_q.push_back(len); else bp_q.push_back(len);
    end
    @(negedge Clk);
    in_meta_valid = 1'b0;
    #1;
    rv = route_valid; rn = route_nf;
  endtask

  task automatic wait_drain(input int budget);
    int w = 0;
    while (exp_q.size() != 0 && w < budget) begin @(negedge Clk); w++; end
    repeat (2) @(negedge Clk);
  endtask

  task automatic test_reset();
    logic [6:0] outs;
    repeat (3) @(negedge Clk);
    in_meta_valid = 1'b1;
    #1;
    outs = {route_valid, route_nf, sel_nf, out_pkt_valid, nf_pkt_ready, bp_pkt_ready, in_meta_ready};
    n_cmp++;
    if (outs !== 7'b0) begin n_err++; $display("FAIL reset_outputs: got %b expected 0000000", outs); end
    n_cmp++;
    if (order_fill !== '0 || stats_route_nf !== 0 || stats_route_bp !== 0) begin
      n_err++; $display("FAIL reset_state: fill=%0d nf=%0d bp=%0d expected 0/0/0", order_fill, stats_route_nf, stats_route_bp);
    end
    in_meta_valid = 1'b0;
    @(negedge Clk); Rst = 1'b0;
    #1;
    n_cmp++;
    if (in_meta_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_ready: got %b expected 1", in_meta_ready); end
  endtask

  task automatic test_mixed();
    logic ok, rv, rn;
    logic need;
    for (int i = 0; i < 4; i++) begin
      need = (i % 2 == 0);
      send_meta(need, 3, 5, ok, rv, rn);
      n_cmp++;
      if (!(ok && rv === 1'b1 && rn === need)) begin
        n_err++; $display("FAIL mixed_route[%0d]: ok=%b rv=%b rn=%b expected 1/1/%b", i, ok, rv, rn, need);
      end
    end
    wait_drain(60);
    n_cmp++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL mixed_drain: %0d packets left expected 0", exp_q.size()); end
    n_cmp++;
    if (stats_route_nf !== 32'd2 || stats_route_bp !== 32'd2) begin
      n_err++; $display("FAIL mixed_stats: nf=%0d bp=%0d expected 2/2", stats_route_nf, stats_route_bp);
    end
  endtask

  task automatic test_congestion();
    logic ok, rv, rn;
    int   hi = 0;
    @(negedge Clk);
    nf_fill_level = 32'd480; in_meta_valid = 1'b1; in_meta_need_nf = 1'b1;
    for (int i = 0; i < 100; i++) begin #1; if (in_meta_ready) hi++; @(negedge Clk); end
    n_cmp++;
    if (hi != 0 || order_fill !== '0 || stats_route_nf !== 32'd2) begin
      n_err++; $display("FAIL cong_stall: ready_cycles=%0d fill=%0d nf=%0d expected 0/0/2", hi, order_fill, stats_route_nf);
    end
    nf_fill_level = 32'd479;
    #1;
    n_cmp++;
    if (in_meta_ready !== 1'b1) begin n_err++; $display("FAIL cong_release: ready=%b expected 1", in_meta_ready); end
    if (in_meta_ready) begin exp_q.push_back(1'b1); nf_q.push_back(2); end
    @(negedge Clk);
    in_meta_valid = 1'b0; nf_fill_level = 32'd480;
    #1;
    n_cmp++;
    if (route_valid !== 1'b1 || route_nf !== 1'b1) begin
      n_err++; $display("FAIL cong_route: rv=%b rn=%b expected 1/1", route_valid, route_nf);
    end
    send_meta(1'b0, 2, 2, ok, rv, rn);
    n_cmp++;
    if (!(ok && rv === 1'b1 && rn === 1'b0)) begin
      n_err++; $display("FAIL cong_bypass: ok=%b rv=%b rn=%b expected 1/1/0", ok, rv, rn);
    end
    nf_fill_level = 32'd0;
    wait_drain(40);
    n_cmp++;
    if (exp_q.size() != 0 || stats_route_nf !== 32'd3 || stats_route_bp !== 32'd3) begin
      n_err++; $display("FAIL cong_stats: left=%0d nf=%0d bp=%0d expected 0/3/3", exp_q.size(), stats_route_nf, stats_route_bp);
    end
  endtask

  task automatic test_order();
    logic ok, rv, rn;
    int   bad = 0;
    bit   seen = 0;
    nf_en = 1'b0;
    send_meta(1'b1, 3, 5, ok, rv, rn);
    send_meta(1'b0, 2, 5, ok, rv, rn);
    repeat (8) begin
      @(negedge Clk); #1;
      if (bp_pkt_ready || out_pkt_valid || sel_nf !== 1'b1) bad++;
    end
    n_cmp++;
    if (bad != 0) begin n_err++; $display("FAIL order_hold: %0d cycles with bypass released early, expected 0", bad); end
    nf_en = 1'b1;
    for (int w = 0; w < 20; w++) begin
      @(negedge Clk); #1;
      if (nf_pkt_valid && nf_pkt_ready && nf_pkt_eop) begin seen = 1; break; end
    end
    n_cmp++;
    if (!seen) begin n_err++; $display("FAIL order_nf_eop: eop seen=%0b expected 1", seen); end
    @(negedge Clk); #1;
    n_cmp++;
    if (sel_nf !== 1'b0 || out_pkt_valid !== 1'b1 || bp_pkt_ready !== 1'b1) begin
      n_err++; $display("FAIL order_no_bubble: sel=%b valid=%b bp_rdy=%b expected 0/1/1", sel_nf, out_pkt_valid, bp_pkt_ready);
    end
    wait_drain(30);
    n_cmp++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL order_drain: %0d left expected 0", exp_q.size()); end
  endtask

  task automatic test_full_wrap();
    logic ok, rv, rn;
    int   bad = 0;
    @(negedge Clk);
    out_pkt_ready = 1'b0;
    // the first tag is popped into a grant, so 33 accepts fill all 32 entries
    for (int i = 0; i < 33; i++) begin
      send_meta(logic'(i % 2), 1, 2, ok, rv, rn);
      if (!ok || rv !== 1'b1 || rn !== logic'(i % 2)) bad++;
    end
    n_cmp++;
    if (bad != 0 || order_fill !== CW'(32)) begin
      n_err++; $display("FAIL full_fill: bad_accepts=%0d fill=%0d expected 0/32", bad, order_fill);
    end
    @(negedge Clk);
    in_meta_valid = 1'b1; in_meta_need_nf = 1'b1;
    #1;
    n_cmp++;
    if (in_meta_ready !== 1'b0) begin n_err++; $display("FAIL full_ready_low: ready=%b expected 0", in_meta_ready); end
    @(negedge Clk);
    out_pkt_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_meta_ready !== 1'b0) begin n_err++; $display("FAIL full_same_cycle: ready=%b expected 0", in_meta_ready); end
    @(negedge Clk); #1;
    n_cmp++;
    if (in_meta_ready !== 1'b1) begin n_err++; $display("FAIL full_lift: ready=%b expected 1", in_meta_ready); end
    if (in_meta_ready) begin exp_q.push_back(1'b1); nf_q.push_back(1); end
    @(negedge Clk);
    in_meta_valid = 1'b0;
    for (int i = 0; i < 8; i++) send_meta(logic'($urandom_range(0, 1)), $urandom_range(1, 3), 5, ok, rv, rn);
    wait_drain(200);
    n_cmp++;
    if (exp_q.size() != 0 || order_fill !== '0) begin
      n_err++; $display("FAIL wrap_drain: left=%0d fill=%0d expected 0/0", exp_q.size(), order_fill);
    end
  endtask

  task automatic test_reset_mid();
    logic ok, rv, rn;
    logic [6:0] outs;
    send_meta(1'b1, 4, 5, ok, rv, rn);
    for (int w = 0; w < 20; w++) begin
      @(negedge Clk); #1;
      if (nf_beat == 1 && nf_pkt_ready) break;
    end
    #1;
    Rst = 1'b1;
    #1;
    outs = {route_valid, route_nf, sel_nf, out_pkt_valid, nf_pkt_ready, bp_pkt_ready, in_meta_ready};
    n_cmp++;
    if (outs !== 7'b0) begin n_err++; $display("FAIL rst_mid_outputs: got %b expected 0000000", outs); end
    n_cmp++;
    if (order_fill !== '0 || dut.r_state !== IDLE || stats_route_nf !== 0 || stats_route_bp !== 0) begin
      n_err++; $display("FAIL rst_mid_state: fill=%0d state=%0d nf=%0d bp=%0d expected 0", order_fill, dut.r_state, stats_route_nf, stats_route_bp);
    end
    repeat (2) @(negedge Clk);
    #1;
    Rst = 1'b0;
    send_meta(1'b0, 2, 5, ok, rv, rn);
    n_cmp++;
    if (!(ok && rv === 1'b1 && rn === 1'b0)) begin
      n_err++; $display("FAIL rst_mid_fresh: ok=%b rv=%b rn=%b expected 1/1/0", ok, rv, rn);
    end
    wait_drain(30);
    n_cmp++;
    if (exp_q.size() != 0 || stats_route_nf !== 32'd0 || stats_route_bp !== 32'd1) begin
      n_err++; $display("FAIL rst_mid_after: left=%0d nf=%0d bp=%0d expected 0/0/1", exp_q.size(), stats_route_nf, stats_route_bp);
    end
  endtask

  task automatic test_stats_wrap();
    logic ok, rv, rn;
    @(negedge Clk);
    force dut.r_stats_bp = 32'hFFFF_FFFE;
    #1;
    release dut.r_stats_bp;
    #1;
    n_cmp++;
    if (stats_route_bp !== 32'hFFFF_FFFE) begin
      n_err++; $display("FAIL wrap_preset: bp=%h expected fffffffe", stats_route_bp);
    end
    send_meta(1'b0, 1, 5, ok, rv, rn);
    send_meta(1'b0, 1, 5, ok, rv, rn);
    wait_drain(20);
    n_cmp++;
    if (stats_route_bp !== 32'd0 || stats_route_nf !== 32'd0) begin
      n_err++; $display("FAIL wrap_stats: bp=%h nf=%0d expected 0/0", stats_route_bp, stats_route_nf);
    end
  endtask

  initial begin
    test_reset();
    test_mixed();
    test_congestion();
    test_order();
    test_full_wrap();
    test_reset_mid();
    test_stats_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
